dcache_mem_ctrl: RTL

DCACHE_MEM_CTRL -- requirements
Module: dcache_mem_ctrl

---
 rtl/dcache_mem_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/dcache_mem_ctrl.sv
// dcache_mem_ctrl: funnels dcache writebacks, write-miss stores and read
// misses through one in-order request FIFO onto the memory bus, tracks
// accepted loads in a small tag table, and turns tagged memory returns into
// a dcache line refill plus a sized, zero-extended load result for the LSQ.
//
// Handshakes:
//   upstream -> FIFO : wb_en/wr_en/rd_en are per-cycle valids; the upstream
//                      ready is !mem_busy, so a request may only be presented
//                      while mem_busy is low. Requests beyond the free slot
//                      count are dropped, never overwriting queued entries.
//   FIFO -> memory   : proc2mem_command != BUS_NONE is the valid; a nonzero
//                      mem2proc_response in the same cycle is the ready and
//                      carries the transaction tag. Without it the head is
//                      held unchanged and re-presented next cycle.
//   memory -> dcache : mem2proc_tag != 0 marks a return; mem_wr_en/ld_valid
//                      are single-cycle pulses with no backpressure.

`ifndef LSQSZ
`define LSQSZ 8
`endif
`ifndef BUS_NONE
`define BUS_NONE 2'h0
`endif
`ifndef BUS_LOAD
`define BUS_LOAD 2'h1
`endif
`ifndef BUS_STORE
`define BUS_STORE 2'h2
`endif
`ifndef BYTE
`define BYTE 2'h0
`endif
`ifndef HALF
`define HALF 2'h1
`endif
`ifndef WORD
`define WORD 2'h2
`endif
`ifndef DOUBLE
`define DOUBLE 2'h3
`endif

module dcache_mem_ctrl #(
  parameter int QDEPTH = 8,
  parameter int NLD    = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               wb_en,
  input  logic [15:0]        wb_addr,
  input  logic [63:0]        wb_data,
  input  logic [1:0]         wb_size,
  input  logic               wr_en,
  input  logic [15:0]        wr_addr,
  input  logic [63:0]        wr_data,
  input  logic [1:0]         wr_size,
  input  logic               rd_en,
  input  logic [15:0]        rd_addr,
  input  logic [1:0]         rd_size,
  input  logic [`LSQSZ-1:0]  rd_gnt,
  output logic               mem_busy,
  output logic [1:0]         proc2mem_command,
  output logic [15:0]        proc2mem_addr,
  output logic [63:0]        proc2mem_data,
  output logic [1:0]         proc2mem_size,
  input  logic [3:0]         mem2proc_response,
  input  logic [63:0]        mem2proc_data,
  input  logic [3:0]         mem2proc_tag,
  output logic               mem_wr_en,
  output logic [4:0]         mem_wr_idx,
  output logic [7:0]         mem_wr_tag,
  output logic [63:0]        mem_wr_data,
  output logic               ld_valid,
  output logic [63:0]        ld_data,
  output logic [`LSQSZ-1:0]  ld_gnt
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam int IW = (NLD > 1) ? $clog2(NLD) : 1;

  // Request FIFO storage: one entry per store or read miss.
  logic              r_q_store [QDEPTH];
  logic [15:0]       r_q_addr  [QDEPTH];
  logic [63:0]       r_q_data  [QDEPTH];
  logic [1:0]        r_q_size  [QDEPTH];
  logic [`LSQSZ-1:0] r_q_gnt   [QDEPTH];
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [CW-1:0]     r_count;
  logic              r_mem_busy;

  // Outstanding-load table.
  logic [NLD-1:0]    r_t_valid;
  logic [3:0]        r_t_tag  [NLD];
  logic [15:0]       r_t_addr [NLD];
  logic [1:0]        r_t_size [NLD];
  logic [`LSQSZ-1:0] r_t_gnt  [NLD];

  // Registered return outputs.
  logic              r_mem_wr_en;
  logic [4:0]        r_mem_wr_idx;
  logic [7:0]        r_mem_wr_tag;
  logic [63:0]       r_mem_wr_data;
  logic              r_ld_valid;
  logic [63:0]       r_ld_data;
  logic [`LSQSZ-1:0] r_ld_gnt;

  logic              w_not_empty;
  logic              w_head_store;
  logic              w_tbl_full;
  logic [1:0]        w_cmd;
  logic [15:0]       w_addr;
  logic [63:0]       w_data;
  logic [1:0]        w_size;
  logic              w_pop;
  logic [CW-1:0]     w_free;
  logic              w_acc_wb;
  logic              w_acc_wr;
  logic              w_acc_rd;
  logic [CW-1:0]     w_n1;
  logic [CW-1:0]     w_n2;
  logic [CW-1:0]     w_npush;
  logic [CW-1:0]     w_count_next;
  logic [CW-1:0]     w_free_next;
  logic [PW-1:0]     w_slot_wb;
  logic [PW-1:0]     w_slot_wr;
  logic [PW-1:0]     w_slot_rd;
  logic              w_match;
  logic [IW-1:0]     w_match_idx;
  logic              w_alloc;
  logic [IW-1:0]     w_alloc_idx;
  logic [15:0]       w_m_addr;
  logic [1:0]        w_m_size;
  logic [`LSQSZ-1:0] w_m_gnt;
  logic [63:0]       w_shifted;
  logic [63:0]       w_ld_data;

  assign w_not_empty  = (r_count != '0);
  assign w_head_store = r_q_store[r_head];
  assign w_tbl_full   = &r_t_valid;

  // Drive the memory port straight from the registered FIFO head; a load
  // head waits (BUS_NONE) while every table entry is in use.
  always_comb begin
    w_cmd  = `BUS_NONE;
    w_addr = '0;
    w_data = '0;
    w_size = '0;
    if (w_not_empty) begin
      if (w_head_store) begin
        w_cmd  = `BUS_STORE;
        w_addr = r_q_addr[r_head];
        w_data = r_q_data[r_head];
        w_size = r_q_size[r_head];
      end else if (!w_tbl_full) begin
        w_cmd  = `BUS_LOAD;
        w_addr = {r_q_addr[r_head][15:3], 3'b000};
        w_size = `DOUBLE;
      end
    end
  end

  assign w_pop   = (w_cmd != `BUS_NONE) && (mem2proc_response != 4'd0);
  assign w_alloc = w_pop && !w_head_store;

  // Admit up to three requests in wb, wr, rd order while slots remain;
  // the head slot being popped this cycle counts as free.
  always_comb begin
    w_free   = CW'(QDEPTH) - r_count + CW'(w_pop);
    w_acc_wb = wb_en && (w_free != '0);
    w_n1     = CW'(w_acc_wb);
    w_acc_wr = wr_en && (w_free > w_n1);
    w_n2     = w_n1 + CW'(w_acc_wr);
    w_acc_rd = rd_en && (w_free > w_n2);
    w_npush  = w_n2 + CW'(w_acc_rd);
    w_slot_wb = r_tail;
    w_slot_wr = r_tail + w_n1[PW-1:0];
    w_slot_rd = r_tail + w_n2[PW-1:0];
    w_count_next = r_count - CW'(w_pop) + w_npush;
    w_free_next  = CW'(QDEPTH) - w_count_next;
  end

  // FIFO pointers, occupancy and the registered busy flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_mem_busy <= 1'b0;
    end else begin
      if (w_pop) r_head <= r_head + PW'(1);
      r_tail     <= r_tail + w_npush[PW-1:0];
      r_count    <= w_count_next;
      r_mem_busy <= (w_free_next < CW'(3));
    end
  end

  // FIFO entry writes; admitted requests always land in distinct slots.
  always_ff @(posedge clock) begin
    if (w_acc_wb) begin
      r_q_store[w_slot_wb] <= 1'b1;
      r_q_addr[w_slot_wb]  <= wb_addr;
      r_q_data[w_slot_wb]  <= wb_data;
      r_q_size[w_slot_wb]  <= wb_size;
      r_q_gnt[w_slot_wb]   <= '0;
    end
    if (w_acc_wr) begin
      r_q_store[w_slot_wr] <= 1'b1;
      r_q_addr[w_slot_wr]  <= wr_addr;
      r_q_data[w_slot_wr]  <= wr_data;
      r_q_size[w_slot_wr]  <= wr_size;
      r_q_gnt[w_slot_wr]   <= '0;
    end
    if (w_acc_rd) begin
      r_q_store[w_slot_rd] <= 1'b0;
      r_q_addr[w_slot_rd]  <= rd_addr;
      r_q_data[w_slot_rd]  <= '0;
      r_q_size[w_slot_rd]  <= rd_size;
      r_q_gnt[w_slot_rd]   <= rd_gnt;
    end
  end

  // Find the lowest valid entry matching the return tag and the lowest free
  // entry for allocation (free is judged before this cycle's release).
  always_comb begin
    w_match     = 1'b0;
    w_match_idx = '0;
    w_alloc_idx = '0;
    for (int i = NLD - 1; i >= 0; i--) begin
      if (r_t_valid[i] && (r_t_tag[i] == mem2proc_tag) && (mem2proc_tag != 4'd0)) begin
        w_match     = 1'b1;
        w_match_idx = IW'(i);
      end
      if (!r_t_valid[i]) w_alloc_idx = IW'(i);
    end
  end

  assign w_m_addr = r_t_addr[w_match_idx];
  assign w_m_size = r_t_size[w_match_idx];
  assign w_m_gnt  = r_t_gnt[w_match_idx];

  // Extract the requested bytes from the returned doubleword.
  always_comb begin
    w_shifted = mem2proc_data >> {w_m_addr[2:0], 3'b000};
    w_ld_data = '0;
    case (w_m_size)
      `BYTE:   w_ld_data = {56'b0, w_shifted[7:0]};
      `HALF:   w_ld_data = {48'b0, w_shifted[15:0]};
      `WORD:   w_ld_data = {32'b0, w_shifted[31:0]};
      default: w_ld_data = w_shifted;
    endcase
  end

  // Table valid bits: release on return match, claim on load acceptance.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_t_valid <= '0;
    end else begin
      if (w_match) r_t_valid[w_match_idx] <= 1'b0;
      if (w_alloc) r_t_valid[w_alloc_idx] <= 1'b1;
    end
  end

  // Table payload captured from the accepted load head.
  always_ff @(posedge clock) begin
    if (w_alloc) begin
      r_t_tag[w_alloc_idx]  <= mem2proc_response;
      r_t_addr[w_alloc_idx] <= r_q_addr[r_head];
      r_t_size[w_alloc_idx] <= r_q_size[r_head];
      r_t_gnt[w_alloc_idx]  <= r_q_gnt[r_head];
    end
  end

  // One-cycle refill and load-result pulse after each matched return.
  always_ff @(posedge clock) begin
    if (reset || !w_match) begin
      r_mem_wr_en   <= 1'b0;
      r_mem_wr_idx  <= '0;
      r_mem_wr_tag  <= '0;
      r_mem_wr_data <= '0;
      r_ld_valid    <= 1'b0;
      r_ld_data     <= '0;
      r_ld_gnt      <= '0;
    end else begin
      r_mem_wr_en   <= 1'b1;
      r_mem_wr_idx  <= w_m_addr[7:3];
      r_mem_wr_tag  <= w_m_addr[15:8];
      r_mem_wr_data <= mem2proc_data;
      r_ld_valid    <= 1'b1;
      r_ld_data     <= w_ld_data;
      r_ld_gnt      <= w_m_gnt;
    end
  end

  assign mem_busy         = r_mem_busy;
  assign proc2mem_command = w_cmd;
  assign proc2mem_addr    = w_addr;
  assign proc2mem_data    = w_data;
  assign proc2mem_size    = w_size;
  assign mem_wr_en        = r_mem_wr_en;
  assign mem_wr_idx       = r_mem_wr_idx;
  assign mem_wr_tag       = r_mem_wr_tag;
  assign mem_wr_data      = r_mem_wr_data;
  assign ld_valid         = r_ld_valid;
  assign ld_data          = r_ld_data;
  assign ld_gnt           = r_ld_gnt;

endmodule
